// File: rtl/zube_wb_pkg.sv
// zube_wb_pkg: shared types for the Wishbone classic initiator.
//   wbi_state_t : initiator FSM states (IDLE, BUS, RESP)
//   wbi_rsp_t   : response record (read data + error flag)
//   bus_result  : maps the end-of-cycle bus event to a response record
package zube_wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wbi_state_t;

    typedef struct packed {
        logic [WB_DATA_W-1:0] data;
        logic                 err;
    } wbi_rsp_t;

    // Data is only returned for a successful read; writes and errors read as 0.
    function automatic wbi_rsp_t bus_result(input logic                 we,
                                            input logic                 err,
                                            input logic [WB_DATA_W-1:0] dat);
        wbi_rsp_t r;
        r.err  = err;
        r.data = (err || we) ? '0 : dat;
        return r;
    endfunction

endpackage

// File: rtl/wb_initiator_timeout.sv
// wb_initiator_timeout: bus-phase watchdog for wb_initiator.
// Only instantiated when WB_INITIATOR_TIMEOUT_EN is defined.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : zero the counter (command accepted, BUS about to start)
//   run      : initiator is in BUS; counter advances once per cycle
//   expired  : this is the TIMEOUT_CYCLES-th BUS cycle with no ack/err
module wb_initiator_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int                 CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // The count holds the number of BUS cycles already completed, so the
    // last allowed cycle is the one where it equals TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = run && (count == LAST);

endmodule

// File: rtl/wb_initiator.sv
// wb_initiator: Wishbone classic (B4, non-pipelined) single-beat master.
// One command in, one 32-bit read or write cycle on the bus, one response out.
//   cmd_*  : command channel (valid/ready), we/addr/data/sel
//   rsp_*  : response channel (valid/ready), data + err
//   wbm_*  : Wishbone master port; cyc == stb, all driven from flops
//   busy   : a transaction is in flight (state != IDLE)
// Optional feature: define WB_INITIATOR_TIMEOUT_EN to abort a BUS phase
// after TIMEOUT_CYCLES cycles without ack/err (reported as rsp_err = 1).
module wb_initiator
    import zube_wb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [ADDR_W-1:0]    cmd_addr,
    input  logic [WB_DATA_W-1:0] cmd_data,
    input  logic [WB_SEL_W-1:0]  cmd_sel,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WB_DATA_W-1:0] rsp_data,
    output logic                 rsp_err,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic                 wbm_we_o,
    output logic [WB_SEL_W-1:0]  wbm_sel_o,
    output logic [ADDR_W-1:0]    wbm_adr_o,
    output logic [WB_DATA_W-1:0] wbm_dat_o,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_err_i,
    input  logic [WB_DATA_W-1:0] wbm_dat_i,
    output logic                 busy
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_initiator: TIMEOUT_CYCLES must be in 1..65535");
    end

    wbi_state_t state_q, state_d;

    logic                 accept;
    logic                 bus_end;
    logic                 timeout_hit;
    logic                 cyc_q;
    logic                 we_q;
    logic [ADDR_W-1:0]    adr_q;
    logic [WB_DATA_W-1:0] dat_q;
    logic [WB_SEL_W-1:0]  sel_q;
    wbi_rsp_t             rsp_q;

    assign accept = (state_q == IDLE) && cmd_valid;

`ifdef WB_INITIATOR_TIMEOUT_EN
    wb_initiator_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clear   (accept),
        .run     (state_q == BUS),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // The slave inputs only matter while in BUS.
    assign bus_end = (state_q == BUS) && (wbm_ack_i || wbm_err_i || timeout_hit);

    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_valid) state_d = BUS;
            BUS:     if (bus_end)   state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: datapath flops are reset too, because every output must read 0
    // while reset is asserted, not just the control state.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            adr_q <= '0;
            dat_q <= '0;
            sel_q <= '0;
            rsp_q <= '0;
        end else begin
            // cyc/stb are a registered copy of "next state is BUS" so they
            // rise at the accepting edge and fall at the ending edge.
            cyc_q <= (state_d == BUS);
            if (accept) begin
                we_q  <= cmd_we;
                adr_q <= cmd_addr;
                dat_q <= cmd_data;
                sel_q <= cmd_sel;
            end
            // Leaving BUS without ack means err or timeout; err beats ack.
            if (bus_end) begin
                rsp_q <= bus_result(we_q, wbm_err_i || !wbm_ack_i, wbm_dat_i);
            end
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_data  = rsp_q.data;
    assign rsp_err   = rsp_q.err;

    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = sel_q;

endmodule

// File: tb/tb_wb_initiator.sv
`timescale 1ns/1ps
module tb_wb_initiator;

    localparam int TO = 8;
`ifdef WB_INITIATOR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_addr, cmd_data;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic        wbm_ack_i, wbm_err_i;
    logic [31:0] wbm_dat_i;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_initiator #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_err_i (wbm_err_i),
        .wbm_dat_i (wbm_dat_i),
        .busy      (busy)
    );

    // mode: 0 = ack, 1 = err, 2 = ack and err together. delay < 0: never answer.
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          delay;
        int          mode;
        logic [31:0] rd;
        int          hold;
        int          exp_stb;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: derive expected response straight from the bus rules.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        bit   timed;
        timed     = TO_EN && (v.delay < 0 || v.delay + 1 > TO);
        r.exp_stb = timed ? TO : v.delay + 1;
        r.exp_err = timed || (v.mode != 0);
        r.exp_data = (r.exp_err || v.we) ? 32'h0 : v.rd;
        return r;
    endfunction

    // Entered and left at posedge+1 with the DUT idle.
    task automatic run_txn(input vec_t v, input string tag);
        int   stb_cycles = 0;
        int   busy_cnt   = 0;
        bit   bus_bad    = 1'b0;
        bit   rsp_bad    = 1'b0;
        check({tag, ".cmd_ready_idle"}, 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_we    = v.we;
        cmd_addr  = v.addr;
        cmd_data  = v.wdata;
        cmd_sel   = v.sel;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_data  = $urandom;
        while (wbm_cyc_o === 1'b1 && stb_cycles < 100) begin
            stb_cycles++;
            if (busy === 1'b1) busy_cnt++;
            if (wbm_stb_o !== 1'b1 || wbm_we_o !== v.we || wbm_adr_o !== v.addr ||
                wbm_dat_o !== v.wdata || wbm_sel_o !== v.sel || rsp_valid !== 1'b0 ||
                cmd_ready !== 1'b0)
                bus_bad = 1'b1;
            if (v.delay >= 0 && stb_cycles == v.delay + 1) begin
                wbm_ack_i = (v.mode != 1);
                wbm_err_i = (v.mode != 0);
                wbm_dat_i = v.rd;
            end else begin
                wbm_dat_i = $urandom;
            end
            @(posedge clk); #1;
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
            wbm_dat_i = $urandom;
        end
        check({tag, ".stb_cycles"}, 64'(stb_cycles), 64'(v.exp_stb));
        check({tag, ".bus_stable"}, 64'(bus_bad), 64'd0);
        check({tag, ".rsp_valid"},  64'(rsp_valid), 64'd1);
        check({tag, ".rsp_err"},    64'(rsp_err), 64'(v.exp_err));
        check({tag, ".rsp_data"},   64'(rsp_data), 64'(v.exp_data));
        check({tag, ".cyc_low"},    64'({wbm_cyc_o, wbm_stb_o}), 64'd0);
        // Hold rsp_ready low while a new command is offered; nothing may move.
        for (int h = 0; h <= v.hold; h++) begin
            if (busy === 1'b1) busy_cnt++;
            if (rsp_valid !== 1'b1 || rsp_err !== v.exp_err || rsp_data !== v.exp_data ||
                cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0)
                rsp_bad = 1'b1;
            cmd_valid = (v.hold > 0);
            rsp_ready = (h == v.hold);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check({tag, ".rsp_stable"}, 64'(rsp_bad), 64'd0);
        check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(v.exp_stb + v.hold + 1));
        check({tag, ".after_hs"}, 64'({cmd_ready, rsp_valid, wbm_cyc_o, busy}), 64'b1000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vec_t v;
        bit   seen_rsp;

        rst = 1'b1; cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_data = 0; cmd_sel = 0;
        rsp_ready = 0; wbm_ack_i = 0; wbm_err_i = 0; wbm_dat_i = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.cmd_ready", 64'(cmd_ready), 64'd1);
        check("reset.ctrl", 64'({rsp_valid, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o, busy}), 64'd0);
        check("reset.data", {rsp_data, wbm_adr_o}, 64'd0);
        check("reset.wdat_sel", 64'({wbm_dat_o, wbm_sel_o}), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        //          we    addr          wdata         sel   dly md rd            hold stb err data
        vecs[0] = '{1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 0, 0, 32'h1111_2222, 0, 1, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h3000_0008, 32'h0,         4'hF, 5, 0, 32'hCAFE_F00D, 0, 6, 1'b0, 32'hCAFE_F00D};
        vecs[2] = '{1'b0, 32'h3000_000C, 32'h0,         4'h3, 2, 2, 32'hDEAD_BEEF, 0, 3, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, 1, 0, 32'h1234_5678, 4, 2, 1'b0, 32'h1234_5678};
        vecs[4] = '{1'b1, 32'h3000_0014, 32'h5555_AAAA, 4'hC, 3, 1, 32'h7777_7777, 1, 4, 1'b1, 32'h0};
        vecs[5] = '{1'b0, 32'h0000_0000, 32'h0,         4'h1, 0, 0, 32'h0000_0000, 0, 1, 1'b0, 32'h0};
        for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

`ifdef WB_INITIATOR_TIMEOUT_EN
        v = '{1'b0, 32'h3000_0020, 32'h0, 4'hF, -1, 0, 32'hBAD0_BAD0, 0, 8, 1'b1, 32'h0};
        run_txn(v, "timeout_noack");
        v = '{1'b0, 32'h3000_0024, 32'h0, 4'hF, 7, 0, 32'h600D_600D, 0, 8, 1'b0, 32'h600D_600D};
        run_txn(v, "timeout_ack_on_expiry");
`else
        v = '{1'b0, 32'h3000_0020, 32'h0, 4'hF, 20, 0, 32'h5107_5107, 0, 21, 1'b0, 32'h5107_5107};
        run_txn(v, "long_wait");
`endif

        for (int i = 0; i < 24; i++) begin
            v.we    = 1'($urandom);
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.sel   = 4'($urandom);
            v.delay = int'($urandom_range(0, 10));
            v.mode  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            v.rd    = $urandom;
            v.hold  = int'($urandom_range(0, 2));
            run_txn(model(v), $sformatf("rnd%0d", i));
        end

        // Reset in the middle of BUS: cyc/stb drop without a clock, no response.
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h3000_0040; cmd_sel = 4'hF;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("rst_bus.cyc_before", 64'(wbm_cyc_o), 64'd1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("rst_bus.async_drop", 64'({wbm_cyc_o, wbm_stb_o, rsp_valid, busy}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen_rsp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) seen_rsp = 1'b1;
            @(posedge clk); #1;
        end
        check("rst_bus.no_rsp", 64'(seen_rsp), 64'd0);
        check("rst_bus.cmd_ready", 64'(cmd_ready), 64'd1);
        run_txn(vecs[1], "rst_bus.next");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_initiator.md
# wb_initiator

Wishbone classic (B4, non-pipelined) bus master. It turns single-beat commands from an on-chip requester (debug bridge, DMA, test sequencer) into one 32-bit Wishbone read or write cycle. It is the initiator counterpart of the user-area Wishbone slave port, so the slave side can be exercised and bridged on-chip. Results are returned on a response channel with an error flag.

## Interface

**Parameters**
- `ADDR_W`, default 32: Wishbone address width.
- `TIMEOUT_CYCLES`, default 255: maximum cycles to wait for `ack`/`err` before aborting. Legal range 1..65535. Only used when the timeout feature is compiled in.

**Ports**
- `wb_clk_i`, in, 1: the single clock.
- `wb_rst_i`, in, 1: reset, asynchronous and active-high.
- `cmd_valid`, in, 1: command offered.
- `cmd_ready`, out, 1: the block can accept a command.
- `cmd_we`, in, 1: 1 = write, 0 = read.
- `cmd_addr`, in, `ADDR_W`: byte address.
- `cmd_data`, in, 32: write data.
- `cmd_sel`, in, 4: byte enables.
- `rsp_valid`, out, 1: response available.
- `rsp_ready`, in, 1: consumer accepts the response.
- `rsp_data`, out, 32: read data. 0 for writes and for errors.
- `rsp_err`, out, 1: the cycle ended with `wbm_err_i` or a timeout.
- `wbm_cyc_o`, out, 1: Wishbone cycle.
- `wbm_stb_o`, out, 1: Wishbone strobe.
- `wbm_we_o`, out, 1: Wishbone write enable.
- `wbm_sel_o`, out, 4: Wishbone byte selects.
- `wbm_adr_o`, out, `ADDR_W`: Wishbone address.
- `wbm_dat_o`, out, 32: Wishbone write data.
- `wbm_ack_i`, in, 1: slave acknowledge.
- `wbm_err_i`, in, 1: slave error.
- `wbm_dat_i`, in, 32: slave read data.
- `busy`, out, 1: a transaction is in flight (state is not IDLE).

## Operation

**State machine:** IDLE → BUS → RESP → IDLE.

- **IDLE.** `cmd_ready` = 1. On `cmd_valid & cmd_ready`:
  - register `we`, `addr`, `data` and `sel`;
  - go to BUS.
- **BUS.**
  - `wbm_cyc_o` = `wbm_stb_o` = 1. All `wbm_*` outputs come from registers and hold steady.
  - On `wbm_err_i`: capture `rsp_err` = 1 and `rsp_data` = 0. `err` has priority over a simultaneous `ack`.
  - Otherwise, on `wbm_ack_i`:
    - capture `rsp_err` = 0;
    - capture `rsp_data` = `wbm_dat_i` for a read, or 0 for a write.
  - Either event leads to RESP.
- **RESP.**
  - `rsp_valid` = 1, with data and err stable.
  - On `rsp_ready`, go to IDLE.
  - `cmd_ready` = 0 here, so there is no overlap: at most one outstanding transaction.

**Other rules**
- `cmd_ready` is combinational from state (IDLE only). It does not depend on `cmd_valid`.
- `wbm_ack_i`, `wbm_err_i` and `wbm_dat_i` are ignored outside BUS.
- `wbm_cyc_o` and `wbm_stb_o` are always equal. There are no burst or tag signals.

**Reset (asynchronous)**
- State returns to IDLE.
- All outputs go to 0, except `cmd_ready`, which is 1 after reset because the block is in IDLE.
- Reset during BUS drops `cyc`/`stb` immediately and produces no response.

## Timing

- Command accepted at edge N → `wbm_cyc_o`/`wbm_stb_o` high from edge N (registered), i.e. visible in cycle N+1.
- `ack` sampled at edge M → `cyc`/`stb` low and `rsp_valid` high after edge M.
- Zero-wait-state slave: command to response costs 2 cycles of `busy`.
- Back-to-back commands: the next `cmd_ready` comes the cycle after `rsp_valid & rsp_ready`. Peak throughput is 1 transaction per 3 cycles.

## Configuration

Macro `WB_INITIATOR_TIMEOUT_EN`.

- **Defined:** a counter clears on entry to BUS and increments each cycle in BUS.
  - When it reaches `TIMEOUT_CYCLES` without `ack`/`err`, the block drops `cyc`/`stb` and enters RESP with `rsp_err` = 1 and `rsp_data` = 0.
  - `ack` in the same cycle as expiry wins, giving a normal response.
- **Undefined:** no counter. BUS waits indefinitely.

## Structure

- **Package `zube_wb_pkg`:**
  - state enum `wbi_state_t` (IDLE, BUS, RESP);
  - `WB_DATA_W` = 32 and `WB_SEL_W` = 4;
  - a response struct holding `data` and `err`.
- **Sub-module `wb_initiator_timeout`:**
  - inputs: `clear`, `run`;
  - output: `expired`;
  - width is `$clog2(TIMEOUT_CYCLES+1)`;
  - instantiated only under the macro.

## Test plan

- Write `addr` 0x3000_0004, `data` 0xA5A5_1234, `sel` 0xF, with `ack` 1 cycle after `stb`:
  - the bus shows those values with `we` = 1;
  - the response has `err` = 0 and `data` = 0;
  - `busy` is high for 2 cycles.
- Read with a 5-cycle `ack` delay and `wbm_dat_i` = 0xCAFE_F00D:
  - `stb` stays high 6 cycles with stable outputs;
  - `rsp_data` = 0xCAFE_F00D.
- `ack` and `err` together on a read → `rsp_err` = 1, `rsp_data` = 0.
- With `rsp_ready` held low for 4 cycles:
  - `rsp_valid` and its data stay stable;
  - `cmd_ready` stays 0;
  - a new `cmd_valid` is not accepted until after the handshake.
- Macro defined with `TIMEOUT_CYCLES` = 8 and no `ack`:
  - `cyc` drops after 8 BUS cycles;
  - `rsp_err` = 1.
- Same setup with `ack` exactly on expiry → normal response, `rsp_err` = 0.
- Assert `wb_rst_i` during BUS:
  - `cyc`/`stb` go low asynchronously;
  - no `rsp_valid` appears;
  - after release `cmd_ready` = 1 and the next command completes normally.
